// File: rtl/pushshift_sched.sv
// Round-robin A/B scheduler plus optional 16-step fill scan driving the push-shift datapath port.
// Latency 1 cycle request->oEn/oAck; registered outputs; requests wait (held) while scan runs.
// Optional scan sequencer compiled in with `define PUSHSHIFT_SCAN_EN.
module pushshift_sched (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       iReqA,
    input  logic [3:0] iAddrA,
    input  logic [3:0] iDataA,
    output logic       oAckA,
    input  logic       iReqB,
    input  logic [3:0] iAddrB,
    input  logic [3:0] iDataB,
    output logic       oAckB,
    input  logic       iScanStart,
    input  logic [3:0] iFill,
    output logic       oScanBusy,
    output logic       oScanDone,
    output logic       oEn,
    output logic [3:0] oAddr,
    output logic [3:0] oData,
    output logic       oWinFull
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic       r_en;
    logic [3:0] r_addr;
    logic [3:0] r_data;
    logic       r_ack_a;
    logic       r_ack_b;
    logic       r_busy;
    logic       r_done;
    logic       r_ptr_b;     // 1: last grant went to B
    logic [2:0] r_win_cnt;

    logic       w_en_nxt;
    logic [3:0] w_addr_nxt;
    logic [3:0] w_data_nxt;
    logic       w_ack_a_nxt;
    logic       w_ack_b_nxt;
    logic       w_busy_nxt;
    logic       w_done_nxt;
    logic       w_ptr_b_nxt;

    logic       w_elig_a;
    logic       w_elig_b;
    logic       w_grant_a;
    logic       w_grant_b;

`ifdef PUSHSHIFT_SCAN_EN
    logic [3:0] r_step;
    logic [3:0] r_fill;
    logic [3:0] w_step_nxt;
    logic [3:0] w_fill_nxt;
`else
    logic       w_unused_scan;
    assign w_unused_scan = ^{iScanStart, iFill};
`endif

    // A request acked this cycle is still high by protocol; skip it once.
    assign w_elig_a  = iReqA & ~r_ack_a;
    assign w_elig_b  = iReqB & ~r_ack_b;
    assign w_grant_a = w_elig_a & (~w_elig_b | r_ptr_b);
    assign w_grant_b = w_elig_b & (~w_elig_a | ~r_ptr_b);

    always_comb begin
        w_state_nxt = r_state;
        w_en_nxt    = 1'b0;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_ack_a_nxt = 1'b0;
        w_ack_b_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_ptr_b_nxt = r_ptr_b;
`ifdef PUSHSHIFT_SCAN_EN
        w_step_nxt  = r_step;
        w_fill_nxt  = r_fill;
`endif
        case (r_state)
            ST_IDLE: begin
`ifdef PUSHSHIFT_SCAN_EN
                if (iScanStart) begin
                    w_state_nxt = ST_SCAN;
                    w_fill_nxt  = iFill;
                    w_step_nxt  = 4'd0;
                    w_en_nxt    = 1'b1;
                    w_addr_nxt  = 4'd0;
                    w_data_nxt  = iFill;
                    w_busy_nxt  = 1'b1;
                end else
`endif
                if (w_grant_a) begin
                    w_en_nxt    = 1'b1;
                    w_addr_nxt  = iAddrA;
                    w_data_nxt  = iDataA;
                    w_ack_a_nxt = 1'b1;
                    w_ptr_b_nxt = 1'b0;
                end else if (w_grant_b) begin
                    w_en_nxt    = 1'b1;
                    w_addr_nxt  = iAddrB;
                    w_data_nxt  = iDataB;
                    w_ack_b_nxt = 1'b1;
                    w_ptr_b_nxt = 1'b1;
                end
            end
            ST_SCAN: begin
`ifdef PUSHSHIFT_SCAN_EN
                // r_step is the address currently on oAddr
                if (r_step == 4'd15) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_step_nxt  = r_step + 4'd1;
                    w_en_nxt    = 1'b1;
                    w_addr_nxt  = r_step + 4'd1;
                    w_data_nxt  = r_fill;
                    w_busy_nxt  = 1'b1;
                end
`else
                w_state_nxt = ST_IDLE;
`endif
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state   <= ST_IDLE;
            r_en      <= 1'b0;
            r_addr    <= 4'd0;
            r_data    <= 4'd0;
            r_ack_a   <= 1'b0;
            r_ack_b   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ptr_b   <= 1'b1;
            r_win_cnt <= 3'd0;
`ifdef PUSHSHIFT_SCAN_EN
            r_step    <= 4'd0;
            r_fill    <= 4'd0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_en      <= w_en_nxt;
            r_addr    <= w_addr_nxt;
            r_data    <= w_data_nxt;
            r_ack_a   <= w_ack_a_nxt;
            r_ack_b   <= w_ack_b_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_ptr_b   <= w_ptr_b_nxt;
            // counts alongside the oEn register so the flag rises with the 6th pulse
            if (w_en_nxt && (r_win_cnt != 3'd6))
                r_win_cnt <= r_win_cnt + 3'd1;
`ifdef PUSHSHIFT_SCAN_EN
            r_step    <= w_step_nxt;
            r_fill    <= w_fill_nxt;
`endif
        end
    end

    assign oEn       = r_en;
    assign oAddr     = r_addr;
    assign oData     = r_data;
    assign oAckA     = r_ack_a;
    assign oAckB     = r_ack_b;
    assign oScanBusy = r_busy;
    assign oScanDone = r_done;
    assign oWinFull  = (r_win_cnt == 3'd6);

endmodule
